// File: rtl/sevseg_scan_driver.sv
// Multiplexed seven-segment driver: captures a binary value, converts it to BCD
// with a serial double-dabble engine and scans the committed digits onto anode/segment pins.
module sevseg_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int IN_W        = 16,
    parameter int BLANK_TICKS = 1
) (
    input  logic              slow_clk,
    input  logic              reset,
    input  logic [IN_W-1:0]   in_val,
    input  logic              load,
    input  logic              lz_suppress,
    input  logic              alt_mode,
    input  logic [DIGITS-1:0] dp_mask,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic              dp,
    output logic              busy,
    output logic              overflow,
    output logic [1:0]        conv_state
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(IN_W + 1);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int TW = 3;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] LIMIT = pow10(DIGITS);

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } conv_state_t;

    conv_state_t      state;
    logic [IN_W-1:0]  bin;
    logic [BW-1:0]    bcd;
    logic [BW-1:0]    bcd_adj;
    logic [CW-1:0]    cnt;
    logic             ovf_cap;
    logic [BW-1:0]    disp_bcd;
    logic             disp_ovf;

    assign conv_state = state;
    assign overflow   = disp_ovf;

    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
    end

    // Converter: IDLE -> CONV (IN_W shifts) -> COMMIT; busy spans CONV and COMMIT.
    always_ff @(posedge slow_clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            bin      <= '0;
            bcd      <= '0;
            cnt      <= '0;
            ovf_cap  <= 1'b0;
            disp_bcd <= '0;
            disp_ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        bin     <= in_val;
                        bcd     <= '0;
                        cnt     <= '0;
                        ovf_cap <= (64'(in_val) >= LIMIT);
                        busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    bcd <= {bcd_adj[BW-2:0], bin[IN_W-1]};
                    bin <= bin << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(IN_W - 1)) state <= COMMIT;
                end
                COMMIT: begin
                    disp_bcd <= bcd;
                    disp_ovf <= ovf_cap;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Forward the commit so slots starting on the commit edge already use the new value.
    logic [BW-1:0] show_bcd;
    logic          show_ovf;
    assign show_bcd = (state == COMMIT) ? bcd : disp_bcd;
    assign show_ovf = (state == COMMIT) ? ovf_cap : disp_ovf;

    logic [DW-1:0] dig, dig_n;
    logic [TW-1:0] tick, tick_n;

    always_comb begin
        if (tick == TW'(BLANK_TICKS)) begin
            tick_n = '0;
            dig_n  = (dig == '0) ? DW'(DIGITS - 1) : dig - 1'b1;
        end else begin
            tick_n = tick + 1'b1;
            dig_n  = dig;
        end
    end

    int         idx;
    int         top_nz;
    logic [6:0] glyph;
    logic       lit;

    always_comb begin
        idx    = int'(dig_n);
        top_nz = 0;
        glyph  = 7'b1111111;
        lit    = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (show_bcd[4*k +: 4] != 4'd0) top_nz = k;
        end
        if (show_ovf) begin
            glyph = 7'b0111111;
        end else if (alt_mode && DIGITS >= 3) begin
            if (idx == 0)      glyph = seg_decode(show_bcd[3:0]);
            else if (idx == 1) glyph = 7'b1110111;
            else               glyph = seg_decode(show_bcd[4*(idx-1) +: 4]);
        end else begin
            glyph = seg_decode(show_bcd[4*idx +: 4]);
            if (lz_suppress && idx > top_nz && idx != 0) lit = 1'b0;
        end
    end

    // Scan position names the slot currently on the pins; outputs load the next slot.
    always_ff @(posedge slow_clk) begin
        if (reset) begin
            dig  <= '0;
            tick <= TW'(BLANK_TICKS);
            an   <= '1;
            seg  <= 7'b1111111;
            dp   <= 1'b1;
        end else begin
            dig  <= dig_n;
            tick <= tick_n;
            if (tick_n == '0 && lit) begin
                an  <= ~(DIGITS'(1) << dig_n);
                seg <= glyph;
                dp  <= ~dp_mask[dig_n];
            end else begin
                an  <= '1;
                seg <= 7'b1111111;
                dp  <= 1'b1;
            end
        end
    end

endmodule
